// File: rtl/reaction_match_ctrl.sv
// reaction_match_ctrl: two-player match scheduler sequencing one shared
// reaction-timer core. Players alternate for N_ROUNDS rounds each. Every
// result is scored into a per-player 20-bit saturating total. The lower
// total wins.
// Optional feature macro: REACTION_BEST_TRACK_EN adds the best0/best1 outputs
// and uses each player's best WIN time to break a tie in totals.
module reaction_match_ctrl #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned N_ROUNDS   = 5,
   parameter int unsigned GAP_MS     = 1000,
   parameter int unsigned PENALTY_MS = 1000,
   parameter int unsigned WDOG_MS    = 20000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        match_start,
   input  logic        abort,
   output logic        tmr_start,
   output logic        tmr_clr,
   input  logic        tmr_done,
   input  logic [1:0]  tmr_code,
   input  logic [15:0] tmr_ms,
   output logic        cur_player,
   output logic [3:0]  round_idx,
   output logic [19:0] total0,
   output logic [19:0] total1,
   output logic [1:0]  winner,
`ifdef REACTION_BEST_TRACK_EN
   output logic [15:0] best0,
   output logic [15:0] best1,
`endif
   output logic        match_done
);

   localparam int unsigned DIV    = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
   localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned MS_MAX = (GAP_MS > WDOG_MS) ? GAP_MS : WDOG_MS;
   localparam int unsigned MS_W   = $clog2(MS_MAX + 2);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
   localparam logic [MS_W-1:0]  GAP_END    = MS_W'(GAP_MS);
   localparam logic [MS_W-1:0]  WDOG_END   = MS_W'(WDOG_MS);
   localparam logic [3:0]       LAST_ROUND = 4'(N_ROUNDS - 1);
   localparam logic [19:0]      PENALTY    = 20'(PENALTY_MS);
   localparam logic [1:0]       CODE_WIN   = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT,
      S_SCORE,
      S_GAP,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
   logic              cur_player_q, cur_player_d;
   logic [3:0]        round_q, round_d;
   logic [19:0]       total0_q, total0_d;
   logic [19:0]       total1_q, total1_d;
   logic [1:0]        winner_q, winner_d;
   logic              match_done_q, match_done_d;
   logic              tmr_start_q, tmr_start_d;
   logic              tmr_clr_q, tmr_clr_d;
   logic [1:0]        res_code_q, res_code_d;
   logic [15:0]       res_ms_q, res_ms_d;
   logic              res_timeout_q, res_timeout_d;
`ifdef REACTION_BEST_TRACK_EN
   logic [15:0]       best0_q, best0_d;
   logic [15:0]       best1_q, best1_d;
`endif

   logic              tick;
   logic              res_is_win;
   logic [19:0]       score_add;
   logic [19:0]       cur_total;
   logic [20:0]       raw_sum;
   logic [19:0]       sat_sum;
   logic [1:0]        win_cmp;

   // Free-running millisecond prescaler; never re-phased by the FSM.
   always_comb begin
      tick       = (tick_cnt_q == DIV_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   // Score of the latched attempt and the saturated total it produces.
   always_comb begin
      res_is_win = (res_code_q == CODE_WIN) && !res_timeout_q;
      score_add  = res_is_win ? {4'b0000, res_ms_q} : PENALTY;
      cur_total  = cur_player_q ? total1_q : total0_q;
      raw_sum    = {1'b0, cur_total} + {1'b0, score_add};
      sat_sum    = raw_sum[20] ? '1 : raw_sum[19:0];
   end

   // Winner from totals; ties fall back to best times when tracked.
   always_comb begin
      if (total0_q < total1_q) begin
         win_cmp = 2'b01;
      end else if (total1_q < total0_q) begin
         win_cmp = 2'b10;
      end else begin
         win_cmp = 2'b11;
`ifdef REACTION_BEST_TRACK_EN
         if (best0_q < best1_q) begin
            win_cmp = 2'b01;
         end else if (best1_q < best0_q) begin
            win_cmp = 2'b10;
         end
`endif
      end
   end

   // Match sequencing: next state, counters, scores and registered outputs.
   always_comb begin
      state_d       = state_q;
      ms_cnt_d      = ms_cnt_q;
      cur_player_d  = cur_player_q;
      round_d       = round_q;
      total0_d      = total0_q;
      total1_d      = total1_q;
      res_code_d    = res_code_q;
      res_ms_d      = res_ms_q;
      res_timeout_d = res_timeout_q;
      tmr_clr_d     = 1'b0;
`ifdef REACTION_BEST_TRACK_EN
      best0_d       = best0_q;
      best1_d       = best1_q;
`endif

      if (abort) begin
         // Abort outranks every same-cycle event, a tmr_done included.
         state_d       = S_IDLE;
         ms_cnt_d      = '0;
         cur_player_d  = 1'b0;
         round_d       = '0;
         total0_d      = '0;
         total1_d      = '0;
         res_code_d    = '0;
         res_ms_d      = '0;
         res_timeout_d = 1'b0;
         tmr_clr_d     = (state_q != S_IDLE);
`ifdef REACTION_BEST_TRACK_EN
         best0_d       = '1;
         best1_d       = '1;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (match_start) begin
                  state_d      = S_ARM;
                  cur_player_d = 1'b0;
                  round_d      = '0;
                  total0_d     = '0;
                  total1_d     = '0;
`ifdef REACTION_BEST_TRACK_EN
                  best0_d      = '1;
                  best1_d      = '1;
`endif
               end
            end
            S_ARM: begin
               ms_cnt_d = '0;
               state_d  = S_WAIT;
            end
            S_WAIT: begin
               if (tmr_done) begin
                  res_code_d    = tmr_code;
                  res_ms_d      = tmr_ms;
                  res_timeout_d = 1'b0;
                  state_d       = S_SCORE;
               end else if (ms_cnt_q == WDOG_END) begin
                  res_timeout_d = 1'b1;
                  state_d       = S_SCORE;
               end else if (tick) begin
                  ms_cnt_d = ms_cnt_q + 1'b1;
               end
            end
            S_SCORE: begin
               if (cur_player_q) begin
                  total1_d = sat_sum;
               end else begin
                  total0_d = sat_sum;
               end
`ifdef REACTION_BEST_TRACK_EN
               if (res_is_win) begin
                  if (!cur_player_q && (res_ms_q < best0_q)) begin
                     best0_d = res_ms_q;
                  end
                  if (cur_player_q && (res_ms_q < best1_q)) begin
                     best1_d = res_ms_q;
                  end
               end
`endif
               ms_cnt_d = '0;
               state_d  = S_GAP;
            end
            S_GAP: begin
               if (ms_cnt_q == GAP_END) begin
                  if (cur_player_q && (round_q == LAST_ROUND)) begin
                     state_d = S_DONE;
                  end else begin
                     cur_player_d = ~cur_player_q;
                     if (cur_player_q) begin
                        round_d = round_q + 1'b1;
                     end
                     state_d = S_ARM;
                  end
               end else if (tick) begin
                  ms_cnt_d = ms_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Outputs are registered from the next state so they align with it.
      tmr_start_d  = (state_d == S_ARM);
      tmr_clr_d    = tmr_clr_d | (state_d == S_SCORE);
      match_done_d = (state_d == S_DONE);
      winner_d     = match_done_d ? win_cmp : 2'b00;
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         tick_cnt_q    <= '0;
         ms_cnt_q      <= '0;
         cur_player_q  <= 1'b0;
         round_q       <= '0;
         total0_q      <= '0;
         total1_q      <= '0;
         winner_q      <= '0;
         match_done_q  <= 1'b0;
         tmr_start_q   <= 1'b0;
         tmr_clr_q     <= 1'b0;
         res_code_q    <= '0;
         res_ms_q      <= '0;
         res_timeout_q <= 1'b0;
`ifdef REACTION_BEST_TRACK_EN
         best0_q       <= '1;
         best1_q       <= '1;
`endif
      end else begin
         state_q       <= state_d;
         tick_cnt_q    <= tick_cnt_d;
         ms_cnt_q      <= ms_cnt_d;
         cur_player_q  <= cur_player_d;
         round_q       <= round_d;
         total0_q      <= total0_d;
         total1_q      <= total1_d;
         winner_q      <= winner_d;
         match_done_q  <= match_done_d;
         tmr_start_q   <= tmr_start_d;
         tmr_clr_q     <= tmr_clr_d;
         res_code_q    <= res_code_d;
         res_ms_q      <= res_ms_d;
         res_timeout_q <= res_timeout_d;
`ifdef REACTION_BEST_TRACK_EN
         best0_q       <= best0_d;
         best1_q       <= best1_d;
`endif
      end
   end

   assign tmr_start  = tmr_start_q;
   assign tmr_clr    = tmr_clr_q;
   assign cur_player = cur_player_q;
   assign round_idx  = round_q;
   assign total0     = total0_q;
   assign total1     = total1_q;
   assign winner     = winner_q;
   assign match_done = match_done_q;
`ifdef REACTION_BEST_TRACK_EN
   assign best0      = best0_q;
   assign best1      = best1_q;
`endif

endmodule

// File: tb/tb_reaction_match_ctrl.sv
// Bench for reaction_match_ctrl: table-driven matches, hand-written corner
// sequences, randomized matches against a score model, and a saturation run
// on a second instance with a large penalty.
module tb_reaction_match_ctrl;

   localparam int unsigned CLK_HZ     = 4000;
   localparam int unsigned N_ROUNDS   = 2;
   localparam int unsigned GAP_MS     = 2;
   localparam int unsigned PENALTY_MS = 1000;
   localparam int unsigned WDOG_MS    = 50;
   localparam int          PEN        = 1000;
   localparam int          SAT_PEN    = 524288;
   localparam int          SAT_MAX    = 1048575;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, match_start, abort, tmr_done;
   logic [1:0]  tmr_code;
   logic [15:0] tmr_ms;
   logic        tmr_start, tmr_clr, cur_player, match_done;
   logic [3:0]  round_idx;
   logic [19:0] total0, total1;
   logic [1:0]  winner;

   logic        s_match_start, s_abort, s_tmr_done;
   logic [1:0]  s_tmr_code;
   logic [15:0] s_tmr_ms;
   logic        s_tmr_start, s_tmr_clr, s_cur_player, s_match_done;
   logic [3:0]  s_round_idx;
   logic [19:0] s_total0, s_total1;
   logic [1:0]  s_winner;
`ifdef REACTION_BEST_TRACK_EN
   logic [15:0] best0, best1, s_best0, s_best1;
`endif

   reaction_match_ctrl #(
      .CLK_HZ(CLK_HZ), .N_ROUNDS(N_ROUNDS), .GAP_MS(GAP_MS),
      .PENALTY_MS(PENALTY_MS), .WDOG_MS(WDOG_MS)
   ) dut (
      .clk(clk), .rst(rst), .match_start(match_start), .abort(abort),
      .tmr_start(tmr_start), .tmr_clr(tmr_clr), .tmr_done(tmr_done),
      .tmr_code(tmr_code), .tmr_ms(tmr_ms), .cur_player(cur_player),
      .round_idx(round_idx), .total0(total0), .total1(total1),
      .winner(winner),
`ifdef REACTION_BEST_TRACK_EN
      .best0(best0), .best1(best1),
`endif
      .match_done(match_done)
   );

   reaction_match_ctrl #(
      .CLK_HZ(CLK_HZ), .N_ROUNDS(3), .GAP_MS(GAP_MS),
      .PENALTY_MS(524288), .WDOG_MS(WDOG_MS)
   ) dut_sat (
      .clk(clk), .rst(rst), .match_start(s_match_start), .abort(s_abort),
      .tmr_start(s_tmr_start), .tmr_clr(s_tmr_clr), .tmr_done(s_tmr_done),
      .tmr_code(s_tmr_code), .tmr_ms(s_tmr_ms), .cur_player(s_cur_player),
      .round_idx(s_round_idx), .total0(s_total0), .total1(s_total1),
      .winner(s_winner),
`ifdef REACTION_BEST_TRACK_EN
      .best0(s_best0), .best1(s_best1),
`endif
      .match_done(s_match_done)
   );

   typedef struct {
      logic [1:0]  code;
      logic [15:0] ms;
      int          exp_t0;
      int          exp_t1;
      logic [1:0]  exp_win;
   } vec_t;

   vec_t vecs [8];
   int   n_pass = 0;
   int   n_checks = 0;
   int   n_start = 0;
   int   n_clr = 0;

   // Pulse counters for the timer handshake outputs.
   always @(negedge clk) begin
      if (tmr_start) n_start++;
      if (tmr_clr) n_clr++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   function automatic int sat20(input int v);
      return (v > SAT_MAX) ? SAT_MAX : v;
   endfunction

   function automatic logic [1:0] model_winner(input int t0, input int t1, input logic [1:0] tie);
      if (t0 < t1) return 2'b01;
      if (t1 < t0) return 2'b10;
      return tie;
   endfunction

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (tmr_start) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (match_done) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   // One attempt: wait for the arm pulse, answer after dly cycles, check
   // ownership, the SCORE-cycle clear pulse, the 2-cycle latency and totals.
   task automatic attempt_chk(input logic [1:0] code, input logic [15:0] ms, input int dly,
                              input logic exp_pl, input logic [3:0] exp_rd,
                              input int prev0, input int prev1, input int exp0, input int exp1);
      bit          ok;
      logic        pl, clr;
      logic [3:0]  rd;
      logic [19:0] p0, p1;
      wait_start(ok);
      check("tmr_start seen", 32'(ok), 1);
      pl = cur_player;
      rd = round_idx;
      step();
      repeat (dly) step();
      tmr_done = 1'b1;
      tmr_code = code;
      tmr_ms   = ms;
      step();
      tmr_done = 1'b0;
      tmr_code = '0;
      tmr_ms   = '0;
      clr = tmr_clr;
      p0  = total0;
      p1  = total1;
      step();
      check("cur_player", 32'(pl), 32'(exp_pl));
      check("round_idx", 32'(rd), 32'(exp_rd));
      check("tmr_clr in SCORE", 32'(clr), 1);
      check("total0 before update", 32'(p0), prev0);
      check("total1 before update", 32'(p1), prev1);
      check("total0", 32'(total0), exp0);
      check("total1", 32'(total1), exp1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL sim_timeout: bench did not complete, got %0d/%0d checks, expected completion", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      bit          ok;
      int          base_s, base_c, cyc, prev0, prev1;
      int          t0, t1, sc, r, st0, st1;
      logic [1:0]  code_r, tie;
      logic [15:0] ms_r;
      vec_t        v;
`ifdef REACTION_BEST_TRACK_EN
      int          b0, b1;
`endif

      // Match A: spec example; match B: EARLY/LATE/code 11 penalties.
      vecs[0] = '{2'b00, 16'd200, 200,  0,    2'b10};
      vecs[1] = '{2'b00, 16'd300, 200,  300,  2'b10};
      vecs[2] = '{2'b00, 16'd250, 450,  300,  2'b10};
      vecs[3] = '{2'b00, 16'd100, 450,  400,  2'b10};
      vecs[4] = '{2'b10, 16'd77,  1000, 0,    2'b01};
      vecs[5] = '{2'b01, 16'd500, 1000, 1000, 2'b01};
      vecs[6] = '{2'b00, 16'd250, 1250, 1000, 2'b01};
      vecs[7] = '{2'b11, 16'd40,  1250, 2000, 2'b01};

      rst = 1'b1; match_start = 1'b0; abort = 1'b0;
      tmr_done = 1'b0; tmr_code = '0; tmr_ms = '0;
      s_match_start = 1'b0; s_abort = 1'b0;
      s_tmr_done = 1'b0; s_tmr_code = '0; s_tmr_ms = '0;
      repeat (3) step();

      check("reset ctrl outputs", 32'({tmr_start, tmr_clr, cur_player, round_idx, match_done, winner}), 0);
      check("reset total0", 32'(total0), 0);
      check("reset total1", 32'(total1), 0);
      check("reset sat totals", 32'(s_total0 | s_total1), 0);
`ifdef REACTION_BEST_TRACK_EN
      check("reset best0", 32'(best0), 32'hFFFF);
      check("reset best1", 32'(best1), 32'hFFFF);
`endif
      rst = 1'b0;
      step();

      // Table-driven matches.
      for (int m = 0; m < 2; m++) begin
         base_s = n_start;
         base_c = n_clr;
         match_start = 1'b1;
         step();
         match_start = 1'b0;
         prev0 = 0;
         prev1 = 0;
         for (int a = 0; a < 4; a++) begin
            v = vecs[m * 4 + a];
            attempt_chk(v.code, v.ms, a, 1'(a % 2), 4'(a / 2), prev0, prev1, v.exp_t0, v.exp_t1);
            prev0 = v.exp_t0;
            prev1 = v.exp_t1;
         end
         wait_done(ok);
         check("match_done reached", 32'(ok), 1);
         check("winner", 32'(winner), 32'(vecs[m * 4 + 3].exp_win));
         check("tmr_start pulse count", n_start - base_s, 4);
         check("tmr_clr pulse count", n_clr - base_c, 4);
      end

      // Equal totals 500/500 (bests 100/200).
      match_start = 1'b1;
      step();
      match_start = 1'b0;
      attempt_chk(2'b00, 16'd400, 0, 1'b0, 4'd0, 0,   0,   400, 0);
      attempt_chk(2'b00, 16'd300, 1, 1'b1, 4'd0, 400, 0,   400, 300);
      attempt_chk(2'b00, 16'd100, 2, 1'b0, 4'd1, 400, 300, 500, 300);
      attempt_chk(2'b00, 16'd200, 0, 1'b1, 4'd1, 500, 300, 500, 500);
      wait_done(ok);
      check("tie match_done", 32'(ok), 1);
`ifdef REACTION_BEST_TRACK_EN
      check("tie winner by best", 32'(winner), 32'(2'b01));
      check("best0", 32'(best0), 100);
      check("best1", 32'(best1), 200);
`else
      check("tie winner", 32'(winner), 32'(2'b11));
`endif

      // Restart from DONE clears totals; stray tmr_done and match_start in GAP ignored.
      match_start = 1'b1;
      step();
      match_start = 1'b0;
      check("restart tmr_start", 32'(tmr_start), 1);
      check("restart clears totals", 32'(total0 | total1), 0);
      check("restart match_done low", 32'({match_done, winner}), 0);
      attempt_chk(2'b00, 16'd150, 0, 1'b0, 4'd0, 0, 0, 150, 0);
      tmr_done = 1'b1; tmr_code = 2'b00; tmr_ms = 16'd9;
      step();
      tmr_done = 1'b0; tmr_ms = '0;
      match_start = 1'b1;
      step();
      match_start = 1'b0;
      check("stray in GAP total0", 32'(total0), 150);
      check("stray in GAP total1", 32'(total1), 0);
      attempt_chk(2'b00, 16'd60, 0, 1'b1, 4'd0, 150, 0, 150, 60);

      // abort in the same cycle as tmr_done.
      wait_start(ok);
      check("pre-abort tmr_start", 32'(ok), 1);
      step();
      tmr_done = 1'b1; tmr_code = 2'b00; tmr_ms = 16'd123; abort = 1'b1;
      step();
      abort = 1'b0; tmr_done = 1'b0; tmr_ms = '0;
      check("abort tmr_clr pulse", 32'(tmr_clr), 1);
      check("abort totals", 32'(total0 | total1), 0);
      check("abort ctrl outputs", 32'({tmr_start, cur_player, round_idx, match_done, winner}), 0);
      step();
      check("abort tmr_clr single", 32'(tmr_clr), 0);

      // Stray tmr_done in IDLE.
      base_s = n_start;
      tmr_done = 1'b1; tmr_code = 2'b00; tmr_ms = 16'd77;
      step();
      tmr_done = 1'b0; tmr_ms = '0;
      repeat (20) step();
      check("idle no tmr_start", n_start - base_s, 0);
      check("idle totals", 32'(total0 | total1), 0);
      check("idle match_done", 32'(match_done), 0);

      // Watchdog timeout.
      match_start = 1'b1;
      step();
      match_start = 1'b0;
      wait_start(ok);
      check("timeout tmr_start", 32'(ok), 1);
      ok = 1'b0;
      cyc = 0;
      for (int i = 0; i < 400; i++) begin
         step();
         cyc++;
         if (tmr_clr) begin
            ok = 1'b1;
            break;
         end
      end
      check("timeout tmr_clr seen", 32'(ok), 1);
      check("timeout cycles in 190..215", 32'((cyc >= 190) && (cyc <= 215)), 1);
      step();
      check("timeout total0", 32'(total0), PEN);
      check("timeout total1", 32'(total1), 0);
      attempt_chk(2'b00, 16'd42, 0, 1'b1, 4'd0, PEN, 0, PEN, 42);
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();

      // Randomized matches against the score model.
      for (int m = 0; m < 4; m++) begin
         t0 = 0;
         t1 = 0;
`ifdef REACTION_BEST_TRACK_EN
         b0 = 65535;
         b1 = 65535;
`endif
         match_start = 1'b1;
         step();
         match_start = 1'b0;
         for (int a = 0; a < 4; a++) begin
            r = int'($urandom_range(0, 9));
            code_r = (r < 6) ? 2'b00 : 2'(r - 6);
            ms_r = (r == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 999));
            sc = (code_r == 2'b00) ? int'(ms_r) : PEN;
            prev0 = t0;
            prev1 = t1;
            if (a % 2 == 0) t0 = sat20(t0 + sc);
            else t1 = sat20(t1 + sc);
`ifdef REACTION_BEST_TRACK_EN
            if (code_r == 2'b00) begin
               if (a % 2 == 0 && int'(ms_r) < b0) b0 = int'(ms_r);
               if (a % 2 == 1 && int'(ms_r) < b1) b1 = int'(ms_r);
            end
`endif
            attempt_chk(code_r, ms_r, int'($urandom_range(0, 5)), 1'(a % 2), 4'(a / 2),
                        prev0, prev1, t0, t1);
         end
         tie = 2'b11;
`ifdef REACTION_BEST_TRACK_EN
         if (b0 < b1) tie = 2'b01;
         else if (b1 < b0) tie = 2'b10;
`endif
         wait_done(ok);
         check("rand match_done", 32'(ok), 1);
         check("rand winner", 32'(winner), 32'(model_winner(t0, t1, tie)));
      end

      // Saturation on the large-penalty instance.
      s_match_start = 1'b1;
      step();
      s_match_start = 1'b0;
      st0 = 0;
      st1 = 0;
      for (int a = 0; a < 6; a++) begin
         ok = 1'b0;
         for (int i = 0; i < 300; i++) begin
            if (s_tmr_start) begin
               ok = 1'b1;
               break;
            end
            step();
         end
         check("sat tmr_start seen", 32'(ok), 1);
         step();
         s_tmr_done = 1'b1; s_tmr_code = 2'b10; s_tmr_ms = 16'd5;
         step();
         s_tmr_done = 1'b0; s_tmr_code = '0; s_tmr_ms = '0;
         step();
         if (a % 2 == 0) st0 = sat20(st0 + SAT_PEN);
         else st1 = sat20(st1 + SAT_PEN);
         check("sat total0", 32'(s_total0), st0);
         check("sat total1", 32'(s_total1), st1);
      end
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (s_match_done) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      check("sat match_done", 32'(ok), 1);
      check("sat winner", 32'(s_winner), 32'(2'b11));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
